unet_maxpool2d: RTL

//  2x2 stride-2 signed max-pool stage directly downstream of the UNet conv2d IP. Reads conv2d's

---
 rtl/unet_pkg.sv | 22 ++
 rtl/unet_maxpool_addr_gen.sv | 115 +++++++++++
 rtl/unet_maxpool2d.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/unet_pkg.sv
// Shared widths, FSM encoding and constants for the UNet max-pool stage.
// Pure declarations: no latency, no backpressure.
package unet_pkg;

    localparam int DATA_W       = 12;
    localparam int IN_ADDR_W    = 15;
    localparam int OUT_ADDR_W   = 15;
    localparam int DIM_W        = 7;
    localparam int SAMPLE_MIN   = -2048;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Position of a read inside its 2x2 window: bit0 = column, bit1 = row.
    typedef logic [1:0] phase_t;

endpackage

// File: rtl/unet_maxpool_addr_gen.sv
// Scan counters and incremental source/destination addressing for 2x2 windows; addresses are
// combinational from registered state (0 cycles); advances once per issued read, never stalls.
module unet_maxpool_addr_gen
    import unet_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DIM_W-1:0]      height,
    input  logic [DIM_W-1:0]      width,
    input  logic [DIM_W-1:0]      channels,
    output logic [IN_ADDR_W-1:0]  rd_adr,
    output logic [OUT_ADDR_W-1:0] wr_adr,
    output phase_t                phase,
    output logic                  last_read
);

    logic [DIM_W-1:0]      ho;
    logic [DIM_W-1:0]      wo;
    logic [2*DIM_W-1:0]    hw_full;
    logic [2*DIM_W-1:0]    howo_full;

    logic [IN_ADDR_W-1:0]  w_reg;
    logic [IN_ADDR_W-1:0]  hw_reg;
    logic [OUT_ADDR_W-1:0] wo_reg;
    logic [OUT_ADDR_W-1:0] howo_reg;
    logic [DIM_W-1:0]      wo_last;
    logic [DIM_W-1:0]      ho_last;
    logic [DIM_W-1:0]      c_last;

    logic [DIM_W-1:0]      ox;
    logic [DIM_W-1:0]      oy;
    logic [DIM_W-1:0]      c;
    logic [IN_ADDR_W-1:0]  src_chan;
    logic [IN_ADDR_W-1:0]  src_row;
    logic [OUT_ADDR_W-1:0] dst_chan;
    logic [OUT_ADDR_W-1:0] dst_row;

    assign ho = height >> 1;
    assign wo = width >> 1;

    // The only multipliers in the block; their results are captured once per job.
    assign hw_full   = {{DIM_W{1'b0}}, height} * {{DIM_W{1'b0}}, width};
    assign howo_full = {{DIM_W{1'b0}}, ho} * {{DIM_W{1'b0}}, wo};

    // src_row already points at row 2*oy of channel c; the phase picks the window corner.
    assign rd_adr = src_row
                  + (phase[1] ? w_reg : '0)
                  + IN_ADDR_W'({ox, 1'b0})
                  + IN_ADDR_W'(phase[0]);

    assign wr_adr = dst_row + OUT_ADDR_W'(ox);

    assign last_read = (phase == 2'd3) && (ox == wo_last) && (oy == ho_last) && (c == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_reg    <= '0;
            hw_reg   <= '0;
            wo_reg   <= '0;
            howo_reg <= '0;
            wo_last  <= '0;
            ho_last  <= '0;
            c_last   <= '0;
            ox       <= '0;
            oy       <= '0;
            c        <= '0;
            phase    <= '0;
            src_chan <= '0;
            src_row  <= '0;
            dst_chan <= '0;
            dst_row  <= '0;
        end else if (load) begin
            w_reg    <= IN_ADDR_W'(width);
            hw_reg   <= IN_ADDR_W'(hw_full);
            wo_reg   <= OUT_ADDR_W'(wo);
            howo_reg <= OUT_ADDR_W'(howo_full);
            wo_last  <= wo - 1'b1;
            ho_last  <= ho - 1'b1;
            c_last   <= channels - 1'b1;
            ox       <= '0;
            oy       <= '0;
            c        <= '0;
            phase    <= '0;
            src_chan <= '0;
            src_row  <= '0;
            dst_chan <= '0;
            dst_row  <= '0;
        end else if (advance) begin
            phase <= phase + 1'b1;
            if (phase == 2'd3) begin
                if (ox != wo_last) begin
                    ox <= ox + 1'b1;
                end else begin
                    ox <= '0;
                    if (oy != ho_last) begin
                        // Two source rows per output row; an odd trailing row is never reached.
                        oy      <= oy + 1'b1;
                        src_row <= src_row + (w_reg << 1);
                        dst_row <= dst_row + wo_reg;
                    end else begin
                        oy       <= '0;
                        c        <= c + 1'b1;
                        src_chan <= src_chan + hw_reg;
                        src_row  <= src_chan + hw_reg;
                        dst_chan <= dst_chan + howo_reg;
                        dst_row  <= dst_chan + howo_reg;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/unet_maxpool2d.sv
// 2x2 stride-2 signed max-pool from conv2d's output buffer into the next layer's input buffer;
// write lands 2 cycles after a window's last read, done 4*C*Ho*Wo+3 after start; no backpressure.
module unet_maxpool2d
    import unet_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      height,
    input  logic [DIM_W-1:0]      width,
    input  logic [DIM_W-1:0]      channels,
    output logic                  busy,
    output logic                  done,
    output logic [IN_ADDR_W-1:0]  in_rsc_radr,
    output logic                  in_rsc_re,
    input  logic [DATA_W-1:0]     in_rsc_q,
    output logic [OUT_ADDR_W-1:0] out_rsc_wadr,
    output logic [DATA_W-1:0]     out_rsc_d,
    output logic                  out_rsc_we
);

    state_t                  state;
    logic                    drain_cnt;
    logic                    accept;
    logic                    degenerate;

    phase_t                  gen_phase;
    logic                    gen_last;
    logic [OUT_ADDR_W-1:0]   gen_wadr;

    logic                    rd_vld_q;
    phase_t                  phase_q;
    logic [OUT_ADDR_W-1:0]   wadr_q;

    logic signed [DATA_W-1:0] q_s;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] win_max;

    assign accept     = start && (state == ST_IDLE);
    assign degenerate = (height < DIM_W'(2)) || (width < DIM_W'(2)) || (channels == '0);

    unet_maxpool_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .advance   (in_rsc_re),
        .height    (height),
        .width     (width),
        .channels  (channels),
        .rd_adr    (in_rsc_radr),
        .wr_adr    (gen_wadr),
        .phase     (gen_phase),
        .last_read (gen_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_rsc_re <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (degenerate) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            busy      <= 1'b1;
                            in_rsc_re <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (gen_last) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                        in_rsc_re <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Covers the RAM read latency plus the output register of the final window.
                    if (drain_cnt == 1'(DRAIN_CYCLES - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag each issued read so the returning sample knows its window position and destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            phase_q  <= '0;
            wadr_q   <= '0;
        end else begin
            rd_vld_q <= in_rsc_re;
            if (in_rsc_re) begin
                phase_q <= gen_phase;
                wadr_q  <= gen_wadr;
            end
        end
    end

    assign q_s     = in_rsc_q;
    assign win_max = (q_s > acc) ? q_s : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc          <= DATA_W'(SAMPLE_MIN);
            out_rsc_we   <= 1'b0;
            out_rsc_d    <= '0;
            out_rsc_wadr <= '0;
        end else begin
            out_rsc_we <= rd_vld_q && (phase_q == 2'd3);
            if (rd_vld_q) begin
                if (phase_q == 2'd0) begin
                    acc <= q_s;
                end else begin
                    acc <= win_max;
                end
                if (phase_q == 2'd3) begin
                    out_rsc_d    <= win_max;
                    out_rsc_wadr <= wadr_q;
                end
            end
        end
    end

endmodule
